neuron_sram_responder: RTL
==========================

Name: neuron_sram_responder

Overview:
- Memory-side responder for the neuron datapath controller. Services its read_enable / write_enable / sram1_address / sram2_address requests.
- Holds three banks: weights (bank 1), inputs (bank 2) and neuron outputs (bank 3, written at an internal sequential pointer).
- Returns registered read data with valid pulses and acknowledges writes.
- Enforces the weight -> input -> write request order and flags violations.
- Also provides a side port for preloading weights/inputs and a port for reading back outputs.

Parameters:
- addr_bits, 9, address width; each bank depth = 2**addr_bits.
- weight_bit, 32, data word width for all banks.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- read_enable  input  1  read request from controller.
- write_enable  input  1  output-write request from controller.
- sram1_address  input  addr_bits  weight bank read address.
- sram2_address  input  addr_bits  input bank read address.
- write_data  input  weight_bit  neuron result to store.
- weight_data  output  weight_bit  registered weight read data.
- weight_valid  output  1  one-cycle pulse, weight_data valid.
- input_data  output  weight_bit  registered input read data.
- input_valid  output  1  one-cycle pulse, input_data valid.
- write_ack  output  1  one-cycle pulse, output write committed.
- out_count  output  addr_bits+1  number of outputs written, saturating at 2**addr_bits.
- out_overflow  output  1  sticky; a write arrived while out_count was saturated.
- protocol_error  output  1  sticky; an out-of-order or illegal request was seen.
- load_en  input  1  preload strobe.
- load_bank  input  1  0 = weight bank, 1 = input bank.
- load_addr  input  addr_bits  preload address.
- load_data  input  weight_bit  preload data.
- load_drop  output  1  one-cycle pulse, preload rejected.
- out_rd_addr  input  addr_bits  output bank readback address.
- out_rd_data  output  weight_bit  registered output bank data (1-cycle latency, always enabled).

Behaviour:
- Reset: state EXPECT_W, wr_ptr = 0, out_count = 0.
  - All outputs 0, including sticky flags.
  - Bank contents are not reset.
  - Reset mid-transaction discards any pending valid/ack pulse.
- Request-order FSM states: EXPECT_W, EXPECT_I, EXPECT_WR.
  - EXPECT_W + read_enable -> read weight_mem[sram1_address]; next cycle weight_data is updated and weight_valid = 1; go to EXPECT_I.
  - EXPECT_I + read_enable -> read input_mem[sram2_address]; next cycle input_data is updated and input_valid = 1; go to EXPECT_WR.
  - EXPECT_WR + write_enable -> write out_mem[wr_ptr] = write_data; next cycle write_ack = 1; wr_ptr += 1; go to EXPECT_W.
  - Idle cycles (no request) hold state; the controller's compute/done/idle gaps are legal.
- Illegal requests set protocol_error, perform no access and leave state unchanged:
  - write_enable in EXPECT_W or EXPECT_I;
  - read_enable in EXPECT_WR;
  - read_enable and write_enable in the same cycle, in any state.
- Read latency is exactly 1 cycle. weight_data / input_data hold their last value between reads.
- wr_ptr wraps modulo 2**addr_bits.
  - out_count increments per committed write and saturates at 2**addr_bits.
  - A write when out_count is saturated still writes, acks and wraps, and also sets out_overflow.
- Preload:
  - Honoured only in cycles where read_enable = 0 and write_enable = 0; writes the selected bank at load_addr, in any FSM state.
  - Otherwise dropped, with load_drop pulsed the next cycle.
  - A preload and a read to the same address in the same cycle cannot occur, because a read drops the preload.
- Output readback is independent of the FSM. A same-cycle write and readback at the same address returns the old data (read-before-write).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Preload weight[5] = 0x11, input[5] = 0x22; read_enable with sram1 = 5, then read_enable with sram2 = 5, then write_enable with write_data = 0x33 -> weight_valid with 0x11, input_valid with 0x22, write_ack; out_rd_addr = 0 returns 0x33; out_count = 1; protocol_error = 0.
- write_enable in EXPECT_W -> protocol_error = 1, no write_ack, out_count unchanged; a following legal sequence still completes normally.
- read_enable and write_enable together in EXPECT_WR -> protocol_error = 1; state stays EXPECT_WR; the next lone write_enable is acked.
- addr_bits = 2: five complete transactions -> out_count = 4; out_overflow = 1 after the 5th; 5th data is at out_mem[0].
- load_en together with read_enable -> load_drop pulses, the target bank is unchanged and the read data is correct.
- Assert reset while in EXPECT_I with a read pending -> no input_valid; state returns to EXPECT_W; all flags clear; preloaded contents are retained.

Source files
------------

// File: rtl/neuron_sram_responder_if.sv
// Request/response bundle between the neuron datapath controller
// and its memory-side responder, plus the preload and readback ports.
interface neuron_sram_responder_if #(
    parameter int addr_bits  = 9,
    parameter int weight_bit = 32
);
    logic                  read_enable;
    logic                  write_enable;
    logic [addr_bits-1:0]  sram1_address;
    logic [addr_bits-1:0]  sram2_address;
    logic [weight_bit-1:0] write_data;
    logic [weight_bit-1:0] weight_data;
    logic                  weight_valid;
    logic [weight_bit-1:0] input_data;
    logic                  input_valid;
    logic                  write_ack;
    logic [addr_bits:0]    out_count;
    logic                  out_overflow;
    logic                  protocol_error;
    logic                  load_en;
    logic                  load_bank;
    logic [addr_bits-1:0]  load_addr;
    logic [weight_bit-1:0] load_data;
    logic                  load_drop;
    logic [addr_bits-1:0]  out_rd_addr;
    logic [weight_bit-1:0] out_rd_data;

    modport master (
        output read_enable, write_enable, sram1_address, sram2_address,
        output write_data, load_en, load_bank, load_addr, load_data,
        output out_rd_addr,
        input  weight_data, weight_valid, input_data, input_valid,
        input  write_ack, out_count, out_overflow, protocol_error,
        input  load_drop, out_rd_data
    );

    modport slave (
        input  read_enable, write_enable, sram1_address, sram2_address,
        input  write_data, load_en, load_bank, load_addr, load_data,
        input  out_rd_addr,
        output weight_data, weight_valid, input_data, input_valid,
        output write_ack, out_count, out_overflow, protocol_error,
        output load_drop, out_rd_data
    );
endinterface

// File: rtl/neuron_sram_responder.sv
// Memory-side responder: weight/input/output banks, enforced
// weight -> input -> write request order, preload and readback ports.
module neuron_sram_responder #(
    parameter int addr_bits  = 9,
    parameter int weight_bit = 32
) (
    input logic                      clk,
    input logic                      reset,
    neuron_sram_responder_if.slave   bus
);
    localparam int DEPTH = 1 << addr_bits;
    localparam logic [addr_bits:0] CNT_MAX = {1'b1, {addr_bits{1'b0}}};

    typedef enum logic [1:0] {
        EXPECT_W  = 2'd0,
        EXPECT_I  = 2'd1,
        EXPECT_WR = 2'd2
    } state_t;

    state_t                r_state;
    logic [weight_bit-1:0] r_weight_mem [DEPTH];
    logic [weight_bit-1:0] r_input_mem  [DEPTH];
    logic [weight_bit-1:0] r_out_mem    [DEPTH];

    logic [addr_bits-1:0]  r_wr_ptr;
    logic [addr_bits:0]    r_out_count;
    logic [weight_bit-1:0] r_weight_data;
    logic [weight_bit-1:0] r_input_data;
    logic [weight_bit-1:0] r_out_rd_data;
    logic                  r_weight_valid;
    logic                  r_input_valid;
    logic                  r_write_ack;
    logic                  r_out_overflow;
    logic                  r_protocol_error;
    logic                  r_load_drop;

    logic w_any_req;
    logic w_do_w;
    logic w_do_i;
    logic w_do_wr;
    logic w_illegal;
    logic w_load_ok;

    assign w_any_req = bus.read_enable | bus.write_enable;
    assign w_do_w    = bus.read_enable & ~bus.write_enable
                     & (r_state == EXPECT_W);
    assign w_do_i    = bus.read_enable & ~bus.write_enable
                     & (r_state == EXPECT_I);
    assign w_do_wr   = bus.write_enable & ~bus.read_enable
                     & (r_state == EXPECT_WR);
    // Any request that is not the one the current state expects.
    assign w_illegal = w_any_req & ~(w_do_w | w_do_i | w_do_wr);
    // Preload only gets the banks when the controller is quiet.
    assign w_load_ok = bus.load_en & ~w_any_req;

    // Bank writes: preload into weight/input, results into outputs.
    always_ff @(posedge clk) begin
        if (w_load_ok && !bus.load_bank)
            r_weight_mem[bus.load_addr] <= bus.load_data;
        if (w_load_ok && bus.load_bank)
            r_input_mem[bus.load_addr] <= bus.load_data;
        if (w_do_wr)
            r_out_mem[r_wr_ptr] <= bus.write_data;
    end

    // Output readback, read-before-write against the result bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_out_rd_data <= '0;
        else
            r_out_rd_data <= r_out_mem[bus.out_rd_addr];
    end

    // Request-order FSM with registered data, pulses and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= EXPECT_W;
            r_wr_ptr         <= '0;
            r_out_count      <= '0;
            r_weight_data    <= '0;
            r_input_data     <= '0;
            r_weight_valid   <= 1'b0;
            r_input_valid    <= 1'b0;
            r_write_ack      <= 1'b0;
            r_out_overflow   <= 1'b0;
            r_protocol_error <= 1'b0;
            r_load_drop      <= 1'b0;
        end else begin
            r_weight_valid <= 1'b0;
            r_input_valid  <= 1'b0;
            r_write_ack    <= 1'b0;
            r_load_drop    <= bus.load_en & w_any_req;
            if (w_illegal)
                r_protocol_error <= 1'b1;
            case (r_state)
                EXPECT_W: begin
                    if (w_do_w) begin
                        r_weight_data  <= r_weight_mem[bus.sram1_address];
                        r_weight_valid <= 1'b1;
                        r_state        <= EXPECT_I;
                    end
                end
                EXPECT_I: begin
                    if (w_do_i) begin
                        r_input_data  <= r_input_mem[bus.sram2_address];
                        r_input_valid <= 1'b1;
                        r_state       <= EXPECT_WR;
                    end
                end
                EXPECT_WR: begin
                    if (w_do_wr) begin
                        r_write_ack <= 1'b1;
                        r_wr_ptr    <= r_wr_ptr + 1'b1;
                        if (r_out_count == CNT_MAX)
                            r_out_overflow <= 1'b1;
                        else
                            r_out_count <= r_out_count + 1'b1;
                        r_state <= EXPECT_W;
                    end
                end
                default: r_state <= EXPECT_W;
            endcase
        end
    end

    assign bus.weight_data    = r_weight_data;
    assign bus.weight_valid   = r_weight_valid;
    assign bus.input_data     = r_input_data;
    assign bus.input_valid    = r_input_valid;
    assign bus.write_ack      = r_write_ack;
    assign bus.out_count      = r_out_count;
    assign bus.out_overflow   = r_out_overflow;
    assign bus.protocol_error = r_protocol_error;
    assign bus.load_drop      = r_load_drop;
    assign bus.out_rd_data    = r_out_rd_data;
endmodule
